// File: rtl/ddr_burst_responder.sv
// rtl/ddr_burst_responder.sv - burst write/read responder backed by on-chip RAM for the frame-buffer DMA bus
module ddr_burst_responder #(
    parameter int BURST_BEATS = 4,
    parameter int RD_LATENCY  = 6,
    parameter int MEM_AW      = 12,
    parameter int INIT_CYCLES = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cmd,
    input  logic        i_cmd_en,
    input  logic [20:0] i_addr,
    input  logic [63:0] i_wr_data,
    input  logic [7:0]  i_data_mask,
    output logic        o_rd_data_valid,
    output logic [63:0] o_rd_data,
    output logic        o_init_done,
    output logic        o_busy,
    output logic        o_cmd_err,
    output logic [15:0] o_err_cnt
);

    localparam int CW = $clog2(INIT_CYCLES + RD_LATENCY + 1);
    localparam int BW = $clog2(BURST_BEATS + 1);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_WR, S_RD_WAIT, S_RD_DATA} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CW-1:0]       r_cnt;
    logic [BW-1:0]       r_beat;
    logic [MEM_AW-1:0]   r_addr;
    logic                r_init_done;
    logic                r_valid;
    logic [63:0]         r_rd_data;
    logic                r_cmd_err;
    logic [15:0]         r_err_cnt;
    logic [63:0]         r_mem [0:(1<<MEM_AW)-1];

    logic                w_accept;
    logic                w_drop;
    logic                w_busy;
    logic                w_wr_en;
    logic [MEM_AW-1:0]   w_wr_addr;
    logic                w_rd_en;
    logic [MEM_AW-1:0]   w_beat_addr;
    logic                w_unused_addr_hi;

    // Upper address bits are deliberately ignored; the RAM only decodes MEM_AW bits.
    assign w_unused_addr_hi = ^i_addr[20:MEM_AW];
    assign w_beat_addr      = r_addr + MEM_AW'(r_beat);

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_INIT;
        else          r_state <= w_next;
    end

    // Next-state decode plus RAM port strobes; a command is only taken while idle
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_busy    = 1'b0;
        w_wr_en   = 1'b0;
        w_wr_addr = w_beat_addr;
        w_rd_en   = 1'b0;
        case (r_state)
            S_INIT: begin
                if (r_cnt == CW'(INIT_CYCLES - 1)) w_next = S_IDLE;
            end
            S_IDLE: begin
                if (i_cmd_en) begin
                    w_accept = 1'b1;
                    if (!i_cmd) begin
                        w_next    = S_WR;
                        w_wr_en   = 1'b1;
                        w_wr_addr = i_addr[MEM_AW-1:0];
                    end else begin
                        w_next = S_RD_WAIT;
                    end
                end
            end
            S_WR: begin
                w_busy  = 1'b1;
                w_wr_en = 1'b1;
                if (r_beat == BW'(BURST_BEATS - 1)) w_next = S_IDLE;
            end
            S_RD_WAIT: begin
                // One cycle is spent entering RD_WAIT and one in the RAM read, hence the -3.
                w_busy = 1'b1;
                if (r_cnt == CW'(RD_LATENCY - 3)) w_next = S_RD_DATA;
            end
            S_RD_DATA: begin
                // Stays one extra cycle so busy covers the final valid beat.
                w_busy = 1'b1;
                if (r_beat == BW'(BURST_BEATS)) w_next = S_IDLE;
                else                            w_rd_en = 1'b1;
            end
            default: w_next = S_INIT;
        endcase
    end

    assign w_drop = i_cmd_en && !w_accept;

    // Counters, latched address, read data register and error reporting
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt       <= '0;
            r_beat      <= '0;
            r_addr      <= '0;
            r_init_done <= 1'b0;
            r_valid     <= 1'b0;
            r_rd_data   <= '0;
            r_cmd_err   <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_cmd_err <= w_drop;
            if (w_drop && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
            r_valid <= w_rd_en;
            if (w_rd_en) r_rd_data <= r_mem[w_beat_addr];
            case (r_state)
                S_INIT: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_next == S_IDLE) r_init_done <= 1'b1;
                end
                S_IDLE: begin
                    r_cnt  <= '0;
                    r_addr <= i_addr[MEM_AW-1:0];
                    r_beat <= i_cmd ? BW'(0) : BW'(1);
                end
                S_WR:      r_beat <= r_beat + BW'(1);
                S_RD_WAIT: r_cnt  <= r_cnt + CW'(1);
                S_RD_DATA: r_beat <= r_beat + BW'(1);
                default:   r_cnt  <= '0;
            endcase
        end
    end

    // Byte-masked RAM write port; contents survive reset
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (!i_data_mask[b]) r_mem[w_wr_addr][8*b +: 8] <= i_wr_data[8*b +: 8];
            end
        end
    end

    assign o_rd_data_valid = r_valid;
    assign o_rd_data       = r_rd_data;
    assign o_init_done     = r_init_done;
    assign o_busy          = w_busy;
    assign o_cmd_err       = r_cmd_err;
    assign o_err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_ddr_burst_responder.sv
// tb/tb_ddr_burst_responder.sv - scoreboard bench for ddr_burst_responder
module tb_ddr_burst_responder;
    localparam int BB = 4;
    localparam int RL = 6;
    localparam int AW = 12;
    localparam int IC = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd = 1'b0;
    logic        cmd_en = 1'b0;
    logic [20:0] addr = '0;
    logic [63:0] wr_data = '0;
    logic [7:0]  data_mask = '0;
    logic        rd_data_valid;
    logic [63:0] rd_data;
    logic        init_done;
    logic        busy;
    logic        cmd_err;
    logic [15:0] err_cnt;

    ddr_burst_responder #(.BURST_BEATS(BB), .RD_LATENCY(RL), .MEM_AW(AW), .INIT_CYCLES(IC)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cmd(cmd), .i_cmd_en(cmd_en), .i_addr(addr),
        .i_wr_data(wr_data), .i_data_mask(data_mask), .o_rd_data_valid(rd_data_valid),
        .o_rd_data(rd_data), .o_init_done(init_done), .o_busy(busy), .o_cmd_err(cmd_err),
        .o_err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [63:0] data; int cyc; } beat_t;
    typedef struct { int cyc; int cnt; } err_t;
    beat_t       exp_q[$];
    err_t        err_q[$];
    logic [63:0] mdl [int];
    int          n_tests = 0;
    int          n_fail = 0;
    int          exp_err_cnt = 0;
    int          pool[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int widx(input logic [20:0] a, input int i);
        return (int'(a[AW-1:0]) + i) % (1 << AW);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a command that must be rejected; caller clears cmd_en after the tick.
    task automatic issue_drop();
        cmd_en = 1'b1;
        cmd    = 1'($urandom_range(0, 1));
        addr   = 21'($urandom);
        if (exp_err_cnt < 65535) exp_err_cnt++;
        err_q.push_back('{cyc + 1, exp_err_cnt});
    endtask

    task automatic do_write(input logic [20:0] a, input logic [BB*64-1:0] d, input logic [BB*8-1:0] m);
        for (int i = 0; i < BB; i++) begin
            cmd_en    = (i == 0);
            cmd       = 1'b0;
            addr      = (i == 0) ? a : 21'($urandom);
            wr_data   = d[i*64 +: 64];
            data_mask = m[i*8 +: 8];
            for (int b = 0; b < 8; b++)
                if (!data_mask[b]) mdl[widx(a, i)][8*b +: 8] = wr_data[8*b +: 8];
            tick();
        end
        cmd_en = 1'b0;
        check("busy_after_wr", busy, 0);
    endtask

    task automatic do_read(input logic [20:0] a, input int drop_at);
        cmd_en = 1'b1;
        cmd    = 1'b1;
        addr   = a;
        for (int i = 0; i < BB; i++) exp_q.push_back('{mdl[widx(a, i)], cyc + RL + i});
        tick();
        cmd_en = 1'b0;
        for (int k = 1; k < RL + BB; k++) begin
            check("busy_during_rd", busy, 1);
            if (k == drop_at) issue_drop();
            tick();
            if (k == drop_at) cmd_en = 1'b0;
        end
        check("busy_after_rd", busy, 0);
    endtask

    function automatic logic [BB*64-1:0] rand_data();
        logic [BB*64-1:0] v;
        for (int i = 0; i < BB * 2; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Scoreboard monitor: compares every presented beat and error pulse against the queues
    always @(negedge clk) begin
        beat_t e;
        err_t  r;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            n_tests++; n_fail++;
            $display("FAIL rd_missing: no beat at cycle %0d, expected data %h", e.cyc, e.data);
        end
        while (err_q.size() > 0 && err_q[0].cyc < cyc) begin
            r = err_q.pop_front();
            n_tests++; n_fail++;
            $display("FAIL err_missing: no cmd_err at cycle %0d", r.cyc);
        end
        if (rd_data_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rd_unexpected: valid at cycle %0d data %h, expected none", cyc, rd_data);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", rd_data, e.data);
                check("rd_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        if (cmd_err) begin
            if (err_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL err_unexpected: cmd_err at cycle %0d, expected none", cyc);
            end else begin
                r = err_q.pop_front();
                check("err_cycle", 64'(cyc), 64'(r.cyc));
                check("err_cnt", 64'(err_cnt), 64'(r.cnt));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [20:0] a;
        int          n;
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_valid", rd_data_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_init_done", init_done, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_err", cmd_err, 0);
        check("rst_err_cnt", err_cnt, 0);

        // Init window with a command at cycle 10 that must be dropped
        rst_n = 1'b1;
        for (int k = 0; k < IC; k++) begin
            check("init_low", init_done, 0);
            if (k == 10) issue_drop();
            tick();
            if (k == 10) cmd_en = 1'b0;
        end
        check("init_high", init_done, 1);

        // Plain write/read-back
        do_write(21'h10, {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}}, '0);
        do_read(21'h10, 0);

        // Partial mask over a preloaded word
        do_write(21'h40, {BB*64{1'b1}}, '0);
        do_write(21'h40, '0, {8'hFF, 8'hFF, 8'h0F, 8'hFF});
        do_read(21'h40, 0);

        // Address wrap with ignored upper bits
        do_write(21'h1FFFFE, rand_data(), '0);
        do_read(21'hFFE, 0);

        // Drop during a read, then back-to-back accept
        do_read(21'h10, 2);
        do_read(21'h40, 0);

        // Randomized traffic over a preloaded pool
        pool = '{12'hFFE, 12'h10, 12'h40};
        for (int i = 0; i < 4; i++) pool.push_back(int'($urandom_range(0, (1 << AW) - 1)));
        foreach (pool[i]) do_write(21'(pool[i]), rand_data(), '0);
        for (int op = 0; op < 40; op++) begin
            a = {9'($urandom), 12'(pool[$urandom_range(0, pool.size() - 1)])};
            if ($urandom_range(0, 1) == 0) begin
                do_write(a, rand_data(), {BB{8'($urandom)}} ^ (BB*8)'($urandom));
            end else begin
                n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, RL + BB - 1)) : 0;
                do_read(a, n);
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        // Reset during beat 2 of a read
        cmd_en = 1'b1;
        cmd    = 1'b1;
        addr   = 21'h10;
        for (int i = 0; i < 3; i++) exp_q.push_back('{mdl[widx(21'h10, i)], cyc + RL + i});
        tick();
        cmd_en = 1'b0;
        for (int k = 1; k < RL + 2; k++) tick();
        rst_n = 1'b0;
        tick();
        check("midrst_valid", rd_data_valid, 0);
        check("midrst_init_done", init_done, 0);
        check("midrst_busy", busy, 0);
        check("midrst_err_cnt", err_cnt, 0);
        exp_err_cnt = 0;
        rst_n = 1'b1;
        repeat (IC - 1) tick();
        check("reinit_low", init_done, 0);
        tick();
        check("reinit_high", init_done, 1);
        do_read(21'h10, 0);
        do_read(21'hFFE, 0);

        repeat (4) tick();
        check("exp_q_empty", 64'(exp_q.size()), 0);
        check("err_q_empty", 64'(err_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
